// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSN_NOP         = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        valid;
    } skid_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {pc, insn, valid} buffer used by instruction_fetch when IF_SKID_EN is defined.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        fill,
    input  logic        take,
    input  logic        flush,
    input  logic [31:0] pc,
    input  logic [31:0] insn,
    output skid_t       q
);

    // fill wins over take so a consume and a new response can share one edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= '0;
        else if (flush)
            q.valid <= 1'b0;
        else if (fill)
            q <= '{pc: pc, insn: insn, valid: 1'b1};
        else if (take)
            q.valid <= 1'b0;
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: IDLE/REQ/HOLD/DRAIN fetch FSM with redirect and variable-latency memory.
// Define IF_SKID_EN to add a one-entry skid buffer for one instruction per cycle.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write,
    input  logic        PC_SRC,
    input  logic [31:0] PC_BRANCH,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] PC_OUT,
    output logic [31:0] IM_OUT,
    output logic        FETCH_VALID
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  target;
    logic [31:0]  pc_inc;
    logic [31:0]  branch;
    logic         ack;
    logic         consume;

    assign ack       = IMEM_REQ & IMEM_ACK;
    assign consume   = FETCH_VALID & write;
    assign pc_inc    = pc + 32'd4;
    assign branch    = word_align(PC_BRANCH);
    assign IMEM_ADDR = pc;

`ifdef IF_SKID_EN
    skid_t skid;
    logic  fill;
    logic  take;
    logic  skid_next_valid;

    // a response in HOLD bypasses the buffer when the current instruction is consumed
    assign fill            = (state == HOLD) & ack & ~consume;
    assign take            = (state == HOLD) & consume & skid.valid;
    assign skid_next_valid = fill | (skid.valid & ~take);

    fetch_skid_buf u_skid (
        .clk   (clk),
        .reset (reset),
        .fill  (fill),
        .take  (take),
        .flush (PC_SRC),
        .pc    (pc),
        .insn  (IMEM_RDATA),
        .q     (skid)
    );
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            target      <= RESET_PC;
            PC_OUT      <= '0;
            IM_OUT      <= '0;
            FETCH_VALID <= 1'b0;
            IMEM_REQ    <= 1'b0;
        end else if (PC_SRC) begin
            FETCH_VALID <= 1'b0;
            IMEM_REQ    <= 1'b1;
            // an unanswered request must finish at its old address before the redirect
            if (IMEM_REQ && !IMEM_ACK) begin
                target <= branch;
                state  <= DRAIN;
            end else begin
                pc    <= branch;
                state <= REQ;
            end
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    IMEM_REQ <= 1'b1;
                end
                REQ: if (ack) begin
                    PC_OUT      <= pc;
                    IM_OUT      <= IMEM_RDATA;
                    FETCH_VALID <= 1'b1;
                    pc          <= pc_inc;
                    state       <= HOLD;
`ifndef IF_SKID_EN
                    IMEM_REQ    <= 1'b0;
`endif
                end
                DRAIN: if (ack) begin
                    pc    <= target;
                    state <= REQ;
                end
`ifdef IF_SKID_EN
                HOLD: begin
                    if (ack)
                        pc <= pc_inc;
                    if (consume && skid.valid) begin
                        PC_OUT <= skid.pc;
                        IM_OUT <= skid.insn;
                    end else if (consume && ack) begin
                        PC_OUT <= pc;
                        IM_OUT <= IMEM_RDATA;
                    end else if (consume) begin
                        FETCH_VALID <= 1'b0;
                        state       <= REQ;
                    end
                    IMEM_REQ <= ~skid_next_valid;
                end
`else
                HOLD: if (consume) begin
                    FETCH_VALID <= 1'b0;
                    IMEM_REQ    <= 1'b1;
                    state       <= REQ;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of instruction_fetch; the skid scenario runs when IF_SKID_EN is defined.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset, write, PC_SRC, force_ack;
    logic [31:0] PC_BRANCH;
    logic        IMEM_REQ, IMEM_ACK, FETCH_VALID;
    logic [31:0] IMEM_ADDR, IMEM_RDATA, PC_OUT, IM_OUT;
    logic        req2, valid2;
    logic [31:0] addr2, pc2, im2;
    int          lat = 0;
    int          wait_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // memory model: acks after lat cycles of a held request, data is address-based
    assign IMEM_ACK   = force_ack | (IMEM_REQ && wait_cnt >= lat);
    assign IMEM_RDATA = IMEM_ADDR + 32'h1000_0000;

    always @(posedge clk)
        wait_cnt <= (!IMEM_REQ || IMEM_ACK) ? 0 : wait_cnt + 1;

    instruction_fetch u_dut (
        .clk         (clk),
        .reset       (reset),
        .write       (write),
        .PC_SRC      (PC_SRC),
        .PC_BRANCH   (PC_BRANCH),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_ACK    (IMEM_ACK),
        .IMEM_RDATA  (IMEM_RDATA),
        .PC_OUT      (PC_OUT),
        .IM_OUT      (IM_OUT),
        .FETCH_VALID (FETCH_VALID)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk         (clk),
        .reset       (reset),
        .write       (1'b1),
        .PC_SRC      (1'b0),
        .PC_BRANCH   (32'h0),
        .IMEM_REQ    (req2),
        .IMEM_ADDR   (addr2),
        .IMEM_ACK    (req2),
        .IMEM_RDATA  (addr2),
        .PC_OUT      (pc2),
        .IM_OUT      (im2),
        .FETCH_VALID (valid2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; write = 1'b1; PC_SRC = 1'b0; PC_BRANCH = '0; force_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", IMEM_REQ, 0);
        check("rst_valid", FETCH_VALID, 0);
        check("rst_pc_out", PC_OUT, 0);
        check("rst_im_out", IM_OUT, 0);
        check("rst_addr", IMEM_ADDR, 0);
        check("rst_wrap_addr", addr2, 32'hFFFF_FFFC);
        reset = 1'b1;
        step();
        check("idle_req", IMEM_REQ, 1);
        check("idle_valid", FETCH_VALID, 0);
        check("wrap_first_addr", addr2, 32'hFFFF_FFFC);
        step();
        check("f0_valid", FETCH_VALID, 1);
        check("f0_pc", PC_OUT, 0);
        check("f0_im", IM_OUT, 32'h1000_0000);
        check("wrap_second_addr", addr2, 32'h0);
        check("wrap_pc_out", pc2, 32'hFFFF_FFFC);
        check("wrap_im_out", im2, 32'hFFFF_FFFC);
        check("wrap_valid", valid2, 1);
`ifdef IF_SKID_EN
        for (int i = 1; i <= 5; i++) begin
            step();
            check("skid_valid", FETCH_VALID, 1);
            check("skid_pc", PC_OUT, 32'(4 * i));
            check("skid_im", IM_OUT, 32'h1000_0000 + 32'(4 * i));
        end
`else
        check("f0_req", IMEM_REQ, 0);
        check("f0_addr", IMEM_ADDR, 4);
        step();
        check("f1_req", IMEM_REQ, 1);
        check("f1_addr", IMEM_ADDR, 4);
        check("f1_valid", FETCH_VALID, 0);
        step();
        check("f1_pc", PC_OUT, 4);
        check("f1_im", IM_OUT, 32'h1000_0004);
        step();
        check("f2_addr", IMEM_ADDR, 8);
        check("f2_req", IMEM_REQ, 1);
        write = 1'b0;
        step();
        check("f2_pc", PC_OUT, 8);
        check("f2_valid", FETCH_VALID, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", FETCH_VALID, 1);
            check("stall_pc", PC_OUT, 8);
            check("stall_im", IM_OUT, 32'h1000_0008);
            check("stall_req", IMEM_REQ, 0);
        end
        write = 1'b1;
        step();
        check("f3_addr", IMEM_ADDR, 12);
        check("f3_valid", FETCH_VALID, 0);
        lat = 3;
        step();
        step();
        check("lat_wait_valid", FETCH_VALID, 0);
        PC_SRC = 1'b1; PC_BRANCH = 32'h0000_0102;
        step();
        PC_SRC = 1'b0;
        check("drain_addr", IMEM_ADDR, 12);
        check("drain_req", IMEM_REQ, 1);
        check("drain_valid", FETCH_VALID, 0);
        step();
        check("redir_addr", IMEM_ADDR, 32'h0000_0100);
        check("redir_stale_valid", FETCH_VALID, 0);
        lat = 0;
        step();
        check("redir_valid", FETCH_VALID, 1);
        check("redir_pc", PC_OUT, 32'h0000_0100);
        check("redir_im", IM_OUT, 32'h1000_0100);
        step();
        check("f4_addr", IMEM_ADDR, 32'h0000_0104);
        PC_SRC = 1'b1; PC_BRANCH = 32'h0000_0200;
        step();
        PC_SRC = 1'b0;
        check("race_valid", FETCH_VALID, 0);
        check("race_addr", IMEM_ADDR, 32'h0000_0200);
        check("race_req", IMEM_REQ, 1);
        step();
        check("race_pc", PC_OUT, 32'h0000_0200);
        check("race_fetch_valid", FETCH_VALID, 1);
        lat = 3;
        step();
        check("pre_rst_addr", IMEM_ADDR, 32'h0000_0204);
        step();
        reset = 1'b0;
        #1;
        check("async_req", IMEM_REQ, 0);
        check("async_valid", FETCH_VALID, 0);
        check("async_addr", IMEM_ADDR, 0);
        check("async_pc_out", PC_OUT, 0);
        @(posedge clk);
        #1;
        reset = 1'b1; force_ack = 1'b1;
        step();
        check("late_ack_valid", FETCH_VALID, 0);
        check("late_ack_addr", IMEM_ADDR, 0);
        check("late_ack_req", IMEM_REQ, 1);
        force_ack = 1'b0; lat = 0;
        step();
        check("after_rst_valid", FETCH_VALID, 1);
        check("after_rst_pc", PC_OUT, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
